// File: rtl/filter_seq_ctrl_pkg.sv
// Shared types for the filter sequencing controller.
// Holds the FSM state encoding and the window-counter width helper.
package filter_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BUF = 3'd1,
    S_READ     = 3'd2,
    S_NEXT_WIN = 3'd3,
    S_ADV      = 3'd4,
    S_DONE     = 3'd5
  } filter_seq_state_t;

  // Window counter width: clog2 of the window count, never below one bit.
  function automatic int unsigned win_width(input int unsigned windows);
    return (windows > 1) ? $clog2(windows) : 1;
  endfunction

endpackage

// File: rtl/filter_seq_ctrl_if.sv
// Handshake and strobe bundle between the top-level controller, the
// filter_seq_ctrl sequencer, and the filter address generator / buffer.
// slave  : the sequencer side (takes start/abort/status, drives strobes).
// master : the environment side.
interface filter_seq_ctrl_if #(
  parameter int unsigned PERF_WIDTH = 16
);

  logic                  start;
  logic                  abort;
  logic                  buf_valid;
  logic                  out_ready;
  logic                  filter_end;
  logic                  finish_filter;

  logic                  rd_valid;
  logic                  filter_cnt_en;
  logic                  ld_filter_head;
  logic                  clr_filter_head;
  logic                  index_cnt_en;
  logic                  clr_index;
  logic                  busy;
  logic                  done;
  logic [PERF_WIDTH-1:0] stall_cnt;

  modport master (
    output start, abort, buf_valid, out_ready, filter_end, finish_filter,
    input  rd_valid, filter_cnt_en, ld_filter_head, clr_filter_head,
           index_cnt_en, clr_index, busy, done, stall_cnt
  );

  modport slave (
    input  start, abort, buf_valid, out_ready, filter_end, finish_filter,
    output rd_valid, filter_cnt_en, ld_filter_head, clr_filter_head,
           index_cnt_en, clr_index, busy, done, stall_cnt
  );

endinterface

// File: rtl/filter_seq_ctrl_counter.sv
// Generic up-counter with synchronous reset, synchronous clear and enable.
// Clear has priority over enable.
module Counter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Count register: reset/clear to zero, otherwise step when enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/filter_seq_ctrl.sv
// filter_seq_ctrl: sequencing FSM for the convolution filter path.
// Drives the Filter_generator strobes from a start/done handshake, replays
// each filter over WINDOWS input windows, and throttles read beats with the
// downstream out_ready handshake.
// Optional feature: define FILTER_SEQ_PERF_EN to build the saturating stall
// counter on stall_cnt; otherwise stall_cnt is tied to zero.
module filter_seq_ctrl
  import filter_seq_pkg::*;
#(
  parameter int unsigned WINDOWS    = 4,
  parameter int unsigned WIN_WIDTH  = win_width(WINDOWS),
  parameter int unsigned PERF_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  filter_seq_ctrl_if.slave  bus
);

  filter_seq_state_t    state;
  filter_seq_state_t    state_nxt;
  logic [WIN_WIDTH-1:0] win_cnt;
  logic                 win_last;
  logic                 win_clr;
  logic                 win_en;

  logic rd_valid_c;
  logic filter_cnt_en_c;
  logic ld_filter_head_c;
  logic clr_filter_head_c;
  logic index_cnt_en_c;
  logic clr_index_c;
  logic start_acc;

  assign win_last = (win_cnt == WIN_WIDTH'(WINDOWS - 1));

  // Window replay counter: cleared at run start, at the last window, on abort.
  Counter #(
    .WIDTH (WIN_WIDTH)
  ) u_win_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (win_clr),
    .en    (win_en),
    .count (win_cnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Mealy strobe decode; abort overrides every transition,
  // and the whole decode is forced quiet while rst is high.
  always_comb begin
    state_nxt         = state;
    rd_valid_c        = 1'b0;
    filter_cnt_en_c   = 1'b0;
    ld_filter_head_c  = 1'b0;
    clr_filter_head_c = 1'b0;
    index_cnt_en_c    = 1'b0;
    clr_index_c       = 1'b0;
    win_clr           = 1'b0;
    win_en            = 1'b0;
    start_acc         = 1'b0;
    if (rst) begin
      state_nxt = S_IDLE;
    end else if (state != S_IDLE && bus.abort) begin
      state_nxt   = S_IDLE;
      clr_index_c = 1'b1;
      win_clr     = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            start_acc         = 1'b1;
            clr_filter_head_c = 1'b1;
            clr_index_c       = 1'b1;
            win_clr           = 1'b1;
            state_nxt         = S_WAIT_BUF;
          end
        end
        S_WAIT_BUF: begin
          if (bus.buf_valid) begin
            state_nxt = S_READ;
          end
        end
        S_READ: begin
          rd_valid_c = 1'b1;
          if (bus.out_ready) begin
            if (bus.filter_end) begin
              clr_index_c = 1'b1;
              state_nxt   = S_NEXT_WIN;
            end else begin
              index_cnt_en_c = 1'b1;
            end
          end
        end
        S_NEXT_WIN: begin
          if (win_last) begin
            win_clr   = 1'b1;
            state_nxt = S_ADV;
          end else begin
            win_en    = 1'b1;
            state_nxt = S_READ;
          end
        end
        S_ADV: begin
          ld_filter_head_c = 1'b1;
          filter_cnt_en_c  = 1'b1;
          state_nxt        = bus.finish_filter ? S_DONE : S_WAIT_BUF;
        end
        S_DONE: begin
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_valid        = rd_valid_c;
  assign bus.filter_cnt_en   = filter_cnt_en_c;
  assign bus.ld_filter_head  = ld_filter_head_c;
  assign bus.clr_filter_head = clr_filter_head_c;
  assign bus.index_cnt_en    = index_cnt_en_c;
  assign bus.clr_index       = clr_index_c;
  assign bus.busy            = (state != S_IDLE);
  assign bus.done            = (state == S_DONE);

`ifdef FILTER_SEQ_PERF_EN
  logic [PERF_WIDTH-1:0] stall_q;
  logic                  stall_inc;

  assign stall_inc = !rst && !bus.abort &&
                     ((state == S_WAIT_BUF && !bus.buf_valid) ||
                      (state == S_READ     && !bus.out_ready));

  // Saturating stall counter, restarted at the beginning of every run.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_q <= '0;
    end else if (stall_inc && stall_q != '1) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = PERF_WIDTH'(0);
`endif

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Directed bench for filter_seq_ctrl with a behavioural Filter_generator
// (FILTER_SIZE=4, NUM=2). Main instance uses WINDOWS=2, a second instance
// uses WINDOWS=1. Cycle 0 of every run is the cycle in which start is high.
module tb_filter_seq_ctrl;

  localparam int unsigned FS = 4;
  localparam int unsigned NUM = 2;
  localparam int unsigned PW = 3;
`ifdef FILTER_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  filter_seq_ctrl_if #(.PERF_WIDTH(PW)) bus ();
  filter_seq_ctrl_if #(.PERF_WIDTH(PW)) bus1 ();

  filter_seq_ctrl #(.WINDOWS(2), .PERF_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  filter_seq_ctrl #(.WINDOWS(1), .PERF_WIDTH(PW)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Behavioural generator models: tap index and filter count per instance.
  int unsigned idx0, fc0, idx1, fc1;
  always @(posedge clk) begin
    if (rst) begin
      idx0 <= 0; fc0 <= 0; idx1 <= 0; fc1 <= 0;
    end else begin
      if (bus.clr_index) idx0 <= 0;
      else if (bus.index_cnt_en) idx0 <= idx0 + 1;
      if (bus.filter_cnt_en) fc0 <= (fc0 + 1) % NUM;
      if (bus1.clr_index) idx1 <= 0;
      else if (bus1.index_cnt_en) idx1 <= idx1 + 1;
      if (bus1.filter_cnt_en) fc1 <= (fc1 + 1) % NUM;
    end
  end
  assign bus.filter_end     = (idx0 == FS - 1);
  assign bus.finish_filter  = (fc0 == NUM - 1);
  assign bus1.filter_end    = (idx1 == FS - 1);
  assign bus1.finish_filter = (fc1 == NUM - 1);
  assign bus1.out_ready     = bus.out_ready;
  assign bus1.buf_valid     = bus.buf_valid;
  assign bus1.abort         = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Per-run records; outv = {rd_valid, filter_cnt_en, ld_filter_head,
  // clr_filter_head, index_cnt_en, clr_index, busy, done}.
  logic [7:0]    outv [0:63];
  logic [PW-1:0] stall_v [0:63];
  int beats, n_done, done_cyc, n_ld, ld_first, ld_last;
  int busy_n, busy_first, busy_last, wait_strobes;
  int beats1, n_done1, done_cyc1, ld1_first, ld1_last;

  task automatic run(input int n, input int or_lo, input int or_hi,
                     input int bv_lo, input int bv_hi, input int ab_cyc,
                     input int rst_cyc, input int st_again, input bit with1);
    beats = 0; n_done = 0; done_cyc = -1; n_ld = 0; ld_first = -1; ld_last = -1;
    busy_n = 0; busy_first = -1; busy_last = -1; wait_strobes = 0;
    beats1 = 0; n_done1 = 0; done_cyc1 = -1; ld1_first = -1; ld1_last = -1;
    for (int cc = 0; cc < n; cc++) begin
      bus.start     = (cc == 0) || (cc == st_again);
      bus1.start    = with1 && (cc == 0);
      bus.out_ready = !(cc >= or_lo && cc <= or_hi);
      bus.buf_valid = !(cc >= bv_lo && cc <= bv_hi);
      bus.abort     = (cc == ab_cyc);
      rst           = (cc == rst_cyc);
      @(negedge clk);
      outv[cc] = {bus.rd_valid, bus.filter_cnt_en, bus.ld_filter_head,
                  bus.clr_filter_head, bus.index_cnt_en, bus.clr_index,
                  bus.busy, bus.done};
      stall_v[cc] = bus.stall_cnt;
      if (bus.rd_valid && bus.out_ready) beats++;
      if (bus.done) begin n_done++; done_cyc = cc; end
      if (bus.ld_filter_head) begin
        n_ld++;
        if (ld_first < 0) ld_first = cc;
        ld_last = cc;
      end
      if (bus.busy) begin
        busy_n++;
        if (busy_first < 0) busy_first = cc;
        busy_last = cc;
      end
      if (!bus.buf_valid && (outv[cc][7:2] != 6'd0)) wait_strobes++;
      if (bus1.rd_valid && bus1.out_ready) beats1++;
      if (bus1.done) begin n_done1++; done_cyc1 = cc; end
      if (bus1.ld_filter_head) begin
        if (ld1_first < 0) ld1_first = cc;
        ld1_last = cc;
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0; bus1.start = 1'b0; bus.abort = 1'b0; rst = 1'b0;
    bus.out_ready = 1'b1; bus.buf_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus1.start = 1'b0; bus.abort = 1'b0;
    bus.out_ready = 1'b1; bus.buf_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_outs", {bus.rd_valid, bus.filter_cnt_en, bus.ld_filter_head,
                         bus.clr_filter_head, bus.index_cnt_en, bus.clr_index,
                         bus.busy, bus.done}, 0);
    check("reset_stall", bus.stall_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Nominal run on both instances.
    run(40, -1, -2, -1, -2, -1, -1, -1, 1'b1);
    check("nom_beats", beats, 16);
    check("nom_done_cnt", n_done, 1);
    check("nom_done_cyc", done_cyc, 25);
    check("nom_ld_cnt", n_ld, 2);
    check("nom_ld_first", ld_first, 12);
    check("nom_ld_last", ld_last, 24);
    check("nom_busy_n", busy_n, 25);
    check("nom_busy_first", busy_first, 1);
    check("nom_busy_last", busy_last, 25);
    check("nom_adv_outs", outv[12], 8'b0110_0010);
    check("nom_wait_outs", outv[13], 8'b0000_0010);
    check("nom_stall", stall_v[39], 0);
    check("w1_beats", beats1, 8);
    check("w1_done_cyc", done_cyc1, 15);
    check("w1_done_cnt", n_done1, 1);
    check("w1_ld_first", ld1_first, 7);
    check("w1_ld_last", ld1_last, 14);

    // out_ready low for cycles 3..5 in the first window.
    run(40, 3, 5, -1, -2, -1, -1, -1, 1'b0);
    check("stl_start_outs", outv[0], 8'b0001_0100);
    check("stl_wb_outs", outv[1], 8'b0000_0010);
    check("stl_hold_outs", outv[4], 8'b1000_0010);
    check("stl_beats", beats, 16);
    check("stl_done_cyc", done_cyc, 28);
    check("stl_done_cnt", n_done, 1);
    check("stl_stall", stall_v[39], PERF ? 3 : 0);

    // buf_valid low for cycles 13..17 before the second filter.
    run(40, -1, -2, 13, 17, -1, -1, -1, 1'b0);
    check("buf_wait_strobes", wait_strobes, 0);
    check("buf_hold_outs", outv[18], 8'b0000_0010);
    check("buf_first_beat", outv[19], 8'b1000_1010);
    check("buf_ld_last", ld_last, 29);
    check("buf_done_cyc", done_cyc, 30);
    check("buf_stall", stall_v[39], PERF ? 5 : 0);

    // Abort during READ at cycle 8.
    run(30, -1, -2, -1, -2, 8, -1, -1, 1'b0);
    check("abt_strobes", outv[8][6:0], 7'b000_0110);
    check("abt_idle_outs", outv[9], 8'b0000_0000);
    check("abt_busy_last", busy_last, 8);
    check("abt_done_cnt", n_done, 0);

    // start together with abort in IDLE is not accepted.
    run(5, -1, -2, -1, -2, 0, -1, -1, 1'b0);
    check("idle_abt_outs", outv[0], 8'b0000_0000);
    check("idle_abt_busy", busy_n, 0);

    // start re-asserted during READ, then rst at cycle 10.
    run(20, -1, -2, -1, -2, -1, 10, 3, 1'b0);
    check("rst_start_ign", outv[3], 8'b1000_1010);
    check("rst_busy_last", busy_last, 10);
    check("rst_outs", outv[11], 8'b0000_0000);
    check("rst_stall", stall_v[11], 0);
    check("rst_done_cnt", n_done, 0);

    // Long WAIT_BUF stall at run start drives the stall counter to its limit.
    run(40, -1, -2, 1, 10, -1, -1, -1, 1'b0);
    check("sat_done_cyc", done_cyc, 35);
    check("sat_stall", stall_v[39], PERF ? 7 : 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/filter_seq_ctrl.md
# filter_seq_ctrl

Sequencing FSM for the convolution filter path: drives the Filter_generator control strobes (head load/clear, index count/clear, filter count) from a start/done handshake. Each filter is replayed over `WINDOWS` input windows before advancing. Read beats are throttled by a downstream valid/ready handshake. Sits between the top-level controller and the filter address generator / filter buffer.

## Interface
- `WINDOWS`, 4: input windows each filter is applied to (≥1).
- `WIN_WIDTH`, `$clog2(WINDOWS)` (min 1): window counter width.
- `PERF_WIDTH`, 16: stall counter width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin run; sampled in IDLE only.
- `abort` in 1: synchronous abort of a run.
- `buf_valid` in 1: filter buffer holds the current filter.
- `out_ready` in 1: downstream accepts a read beat.
- `filter_end` in 1: generator index is at the last tap.
- `finish_filter` in 1: generator filter count is at the last filter.
- `rd_valid` out 1: `filter_raddr` is valid this cycle.
- `filter_cnt_en`, `ld_filter_head`, `clr_filter_head`, `index_cnt_en`, `clr_index` out 1 each: generator strobes.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of run.
- `stall_cnt` out `PERF_WIDTH`: stall cycles; see Configuration.

## Operation
- States: IDLE, WAIT_BUF, READ, NEXT_WIN, ADV, DONE. Encoding is 3-bit binary.
- IDLE: on `start & ~abort`, pulse `clr_filter_head` and `clr_index`, zero `win_cnt`, then go to WAIT_BUF.
- WAIT_BUF: hold while `buf_valid` is 0; go to READ when it is 1.
- READ: `rd_valid`=1. A beat is accepted when `out_ready`=1.
  - Accepted beat with `filter_end`=0: `index_cnt_en`=1.
  - Accepted beat with `filter_end`=1: `clr_index`=1, go to NEXT_WIN.
  - `out_ready`=0: hold all state; no strobes.
- NEXT_WIN:
  - If `win_cnt`==`WINDOWS`-1: clear `win_cnt`, go to ADV.
  - Otherwise: increment `win_cnt`, go to READ to replay the same filter.
- ADV: `ld_filter_head`=1 and `filter_cnt_en`=1. `finish_filter` is sampled before the increment.
  - `finish_filter`=1: go to DONE.
  - Otherwise: go to WAIT_BUF.
- DONE: `done`=1, then go to IDLE.
- `abort` in any non-IDLE state: next state is IDLE, `clr_index`=1 that cycle, no other strobes. `abort` has priority over every other transition.
- `start` is ignored when not in IDLE.
- The generator's filter counter has no clear input. Back-to-back runs therefore require a power-of-two filter count, so the counter wraps on the final ADV. Otherwise `rst` must be asserted between runs.

## Timing
- Strobes and `rd_valid` are combinational from state and inputs (Mealy), so `index_cnt_en` coincides with the accepted beat.
- `busy`, `done` and state are decoded from registered state.
- Reset: state IDLE, `win_cnt`=0, `stall_cnt`=0, all outputs 0.
- Latency with `start` at cycle 0: WAIT_BUF at cycle 1; first `rd_valid` at cycle 2 if `buf_valid`=1.
- Cost per filter:
  - `FILTER_SIZE` accepted beats per window.
  - +1 cycle (NEXT_WIN) per window.
  - +1 cycle (ADV) per filter.
  - ≥1 cycle (WAIT_BUF) per filter after the first.
- `rst` mid-run: IDLE next cycle; no `done`.

## Configuration
- `FILTER_SEQ_PERF_EN` defined: `stall_cnt` increments each cycle in READ with `out_ready`=0, and each cycle in WAIT_BUF with `buf_valid`=0.
  - Saturates at all-ones.
  - Clears on `rst` and on the IDLE→WAIT_BUF transition.
- `FILTER_SEQ_PERF_EN` undefined: `stall_cnt` is tied to 0 and no counter logic is generated.

## Structure
- Package `filter_seq_pkg`: state typedef `filter_seq_state_t` and its 3-bit encodings.
- Sub-module: the existing `Counter` instantiated for `win_cnt`, with width `WIN_WIDTH` and `clr` driven by start / NEXT_WIN wrap / abort.
- The FSM and strobe decode live in a single always block pair.

## Test plan
- Setup for the first three tests: a Filter_generator instance with FILTER_SIZE=4, NUM=2, `WINDOWS`=2.
- Nominal run, `out_ready`=`buf_valid`=1, `start` at cycle 0 → 16 `rd_valid` beats, `ld_filter_head` at cycles 12 and 24, `done` at cycle 25 only, `busy` cycles 1–25.
- `out_ready` low for 3 cycles mid-filter → beat sequence unchanged, `done` at cycle 28, `stall_cnt`=3 (with the macro).
- `buf_valid` low 5 cycles before the second filter → WAIT_BUF holds 5 extra cycles, no strobes while waiting, `done` at cycle 30.
- `abort` at cycle 8 → IDLE at cycle 9, `clr_index` at cycle 8, no `done`, `busy`=0 at cycle 9.
- `start` asserted during READ and `rst` at cycle 10 → start ignored; after reset all outputs 0 and state IDLE.
- `WINDOWS`=1 → no replay: NEXT_WIN goes directly to ADV after every filter.
